// File: rtl/mem_port_arb_pkg.sv
// -----------------------------------------------------------------------------
// mem_port_arb_pkg
// Shared types and defaults for the two-requester Mem port arbiter.
//   arb_state_t : arbiter FSM states (IDLE, ACCESS, DONE)
//   req_id_t    : requester id, 0 = req0, 1 = req1
//   ADDR_W_DEF / DATA_W_DEF : default widths matching the Mem block
// -----------------------------------------------------------------------------
package mem_port_arb_pkg;

  localparam int ADDR_W_DEF = 2;
  localparam int DATA_W_DEF = 2;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } arb_state_t;

  typedef logic req_id_t;

endpackage

// File: rtl/rr_arb2.sv
// -----------------------------------------------------------------------------
// rr_arb2
// Two-way arbiter. Combinational one-hot grant from {valid1, valid0}; the
// round-robin pointer moves to favour the other requester on a done strobe.
// Build option: MEM_PORT_ARB_FIXED_PRIO_EN selects fixed priority (req0 wins,
// no pointer).
// Ports:
//   clk      in   system clock
//   rst      in   synchronous active-high reset (pointer favours req0)
//   valid    in   [1:0] request valids, bit n = requester n
//   done_stb in   access finished this cycle
//   done_id  in   requester that owned the finished access
//   grant    out  [1:0] one-hot grant (all zero when nothing is valid)
// -----------------------------------------------------------------------------
module rr_arb2
  import mem_port_arb_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] valid,
  input  logic       done_stb,
  input  req_id_t    done_id,
  output logic [1:0] grant
);

`ifdef MEM_PORT_ARB_FIXED_PRIO_EN

  always_comb begin
    grant = 2'b00;
    if (valid[0])      grant = 2'b01;
    else if (valid[1]) grant = 2'b10;
  end

  // Pointer inputs have no meaning in fixed-priority mode.
  logic unused_rr;
  assign unused_rr = ^{clk, rst, done_stb, done_id};

`else

  // 0 favours req0, 1 favours req1.
  req_id_t ptr;

  always_ff @(posedge clk) begin
    if (rst)           ptr <= 1'b0;
    else if (done_stb) ptr <= ~done_id;
  end

  always_comb begin
    grant = 2'b00;
    case (valid)
      2'b01:   grant = 2'b01;
      2'b10:   grant = 2'b10;
      2'b11:   grant = ptr ? 2'b10 : 2'b01;
      default: grant = 2'b00;
    endcase
  end

`endif

endmodule

// File: rtl/mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// mem_port_arbiter
// Shares the single-port Mem block between two requesters. A winning request
// is latched in IDLE, drives the memory for exactly one ACCESS cycle, and
// completes with a done pulse (plus read data) in DONE. mem_load stays 1 at
// all times except the ACCESS cycle of a write.
// Build option: MEM_PORT_ARB_FIXED_PRIO_EN (fixed priority, see rr_arb2).
//
//   state  | meaning
//   -------+------------------------------------------------------------
//   IDLE   | sample valids, pulse winner's ready, latch its request
//   ACCESS | drive Mem from the latch; capture read data at cycle end
//   DONE   | pulse winner's done with rdata; advance round-robin pointer
//
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   reqN_valid/load/addr/wdata  request from requester N (load 1 = read)
//   reqN_ready               one-cycle accept pulse
//   reqN_done                one-cycle completion pulse
//   reqN_rdata               read data, valid while reqN_done is high
//   mem_address/mem_val/mem_load  to Mem
//   mem_loaded_stored        read data from Mem
// -----------------------------------------------------------------------------
module mem_port_arbiter
  import mem_port_arb_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              rst,

  input  logic              req0_valid,
  input  logic              req0_load,
  input  logic [ADDR_W-1:0] req0_addr,
  input  logic [DATA_W-1:0] req0_wdata,
  output logic              req0_ready,
  output logic              req0_done,
  output logic [DATA_W-1:0] req0_rdata,

  input  logic              req1_valid,
  input  logic              req1_load,
  input  logic [ADDR_W-1:0] req1_addr,
  input  logic [DATA_W-1:0] req1_wdata,
  output logic              req1_ready,
  output logic              req1_done,
  output logic [DATA_W-1:0] req1_rdata,

  output logic [ADDR_W-1:0] mem_address,
  output logic [DATA_W-1:0] mem_val,
  output logic              mem_load,
  input  logic [DATA_W-1:0] mem_loaded_stored
);

  arb_state_t        state, next_state;
  logic [1:0]        grant;
  logic              accept;
  logic              ready0_c, ready1_c, done0_c, done1_c;

  logic              lat_load;
  logic [ADDR_W-1:0] lat_addr;
  logic [DATA_W-1:0] lat_wdata;
  req_id_t           lat_id;
  logic [DATA_W-1:0] rdata_q;

  rr_arb2 u_arb (
    .clk      (clk),
    .rst      (rst),
    .valid    ({req1_valid, req0_valid}),
    .done_stb (state == DONE),
    .done_id  (lat_id),
    .grant    (grant)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  always_comb begin
    next_state = state;
    accept     = 1'b0;
    ready0_c   = 1'b0;
    ready1_c   = 1'b0;
    done0_c    = 1'b0;
    done1_c    = 1'b0;
    mem_load   = 1'b1;
    case (state)
      IDLE: begin
        if (|grant) begin
          accept     = 1'b1;
          ready0_c   = grant[0];
          ready1_c   = grant[1];
          next_state = ACCESS;
        end
      end
      ACCESS: begin
        mem_load   = lat_load;
        next_state = DONE;
      end
      DONE: begin
        done0_c    = (lat_id == 1'b0);
        done1_c    = (lat_id == 1'b1);
        next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  // Handshakes are suppressed while rst is high so a reset cycle never
  // reports an accept or a completion that is about to be discarded.
  assign req0_ready = ready0_c & ~rst;
  assign req1_ready = ready1_c & ~rst;
  assign req0_done  = done0_c & ~rst;
  assign req1_done  = done1_c & ~rst;

  always_ff @(posedge clk) begin
    if (rst) begin
      lat_load  <= 1'b1;
      lat_addr  <= '0;
      lat_wdata <= '0;
      lat_id    <= 1'b0;
      rdata_q   <= '0;
    end else begin
      if (accept) begin
        lat_id    <= grant[1];
        lat_load  <= grant[1] ? req1_load  : req0_load;
        lat_addr  <= grant[1] ? req1_addr  : req0_addr;
        lat_wdata <= grant[1] ? req1_wdata : req0_wdata;
      end
      // Writes leave rdata_q alone so it keeps the last read value.
      if ((state == ACCESS) && lat_load)
        rdata_q <= mem_loaded_stored;
    end
  end

  // The latch itself drives the address/data pins, so they only change on
  // an accept and otherwise hold their last value.
  assign mem_address = lat_addr;
  assign mem_val     = lat_wdata;

  assign req0_rdata = req0_done ? rdata_q : '0;
  assign req1_rdata = req1_done ? rdata_q : '0;

endmodule

// File: tb/tb_mem_port_arbiter.sv
module tb_mem_port_arbiter;
  import mem_port_arb_pkg::*;

  localparam int AW = 2;
  localparam int DW = 2;

  logic          clk = 1'b0;
  logic          rst;
  logic          req0_valid, req0_load, req1_valid, req1_load;
  logic [AW-1:0] req0_addr, req1_addr;
  logic [DW-1:0] req0_wdata, req1_wdata;
  logic          req0_ready, req0_done, req1_ready, req1_done;
  logic [DW-1:0] req0_rdata, req1_rdata;
  logic [AW-1:0] mem_address;
  logic [DW-1:0] mem_val;
  logic          mem_load;
  logic [DW-1:0] mem_loaded_stored;

  always #5 clk = ~clk;

  mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk               (clk),
    .rst               (rst),
    .req0_valid        (req0_valid),
    .req0_load         (req0_load),
    .req0_addr         (req0_addr),
    .req0_wdata        (req0_wdata),
    .req0_ready        (req0_ready),
    .req0_done         (req0_done),
    .req0_rdata        (req0_rdata),
    .req1_valid        (req1_valid),
    .req1_load         (req1_load),
    .req1_addr         (req1_addr),
    .req1_wdata        (req1_wdata),
    .req1_ready        (req1_ready),
    .req1_done         (req1_done),
    .req1_rdata        (req1_rdata),
    .mem_address       (mem_address),
    .mem_val           (mem_val),
    .mem_load          (mem_load),
    .mem_loaded_stored (mem_loaded_stored)
  );

  // Behavioural Mem: asynchronous read, write on the clock edge when load=0.
  logic          mem_init;
  logic [DW-1:0] mem_arr [4];

  always @(posedge clk) begin
    if (mem_init) begin
      for (int i = 0; i < 4; i++) mem_arr[i] <= '0;
    end else if (!mem_load) begin
      mem_arr[mem_address] <= mem_val;
    end
  end
  assign mem_loaded_stored = mem_arr[mem_address];

  // Scoreboard of expected completions, in order.
  typedef struct {
    logic          id;
    logic          load;
    logic [DW-1:0] rdata;
  } exp_t;
  exp_t sb[$];

  // Bench's own view of what Mem should contain.
  logic [DW-1:0] shadow [4];

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic adv();
    @(posedge clk);
    #1;
  endtask

  // Settle combinational outputs, then run the per-cycle checks.
  task automatic settle();
    exp_t e;
    int   hot;
    #1;
    hot = int'(req0_ready) + int'(req1_ready) + int'(req0_done) + int'(req1_done);
    check("handshake_exclusive", 32'(hot <= 1), 32'd1);
    if (req0_done || req1_done) begin
      if (sb.size() == 0) begin
        check("unexpected_done", {30'd0, req1_done, req0_done}, 32'd0);
      end else begin
        e = sb.pop_front();
        check("done_id", {30'd0, req1_done, req0_done}, e.id ? 32'd2 : 32'd1);
        if (e.load)
          check("rdata", e.id ? 32'(req1_rdata) : 32'(req0_rdata), 32'(e.rdata));
      end
    end
  endtask

  task automatic push(input logic id, input logic load, input logic [DW-1:0] rd);
    exp_t e;
    e.id    = id;
    e.load  = load;
    e.rdata = rd;
    sb.push_back(e);
  endtask

  initial begin
    rst        = 1'b1;
    mem_init   = 1'b1;
    req0_valid = 1'b0; req0_load = 1'b1; req0_addr = '0; req0_wdata = '0;
    req1_valid = 1'b0; req1_load = 1'b1; req1_addr = '0; req1_wdata = '0;
    for (int i = 0; i < 4; i++) shadow[i] = '0;

    // Reset state
    adv(); adv();
    mem_init = 1'b0;
    settle();
    check("rst_mem_load", 32'(mem_load), 32'd1);
    check("rst_mem_address", 32'(mem_address), 32'd0);
    check("rst_mem_val", 32'(mem_val), 32'd0);
    check("rst_handshakes", {28'd0, req0_ready, req1_ready, req0_done, req1_done}, 32'd0);
    check("rst_rdata", {28'd0, req0_rdata, req1_rdata}, 32'd0);
    rst = 1'b0;

    // Idle safety
    for (int c = 0; c < 20; c++) begin
      adv(); settle();
      check("idle_mem_load", 32'(mem_load), 32'd1);
      check("idle_handshakes", {28'd0, req0_ready, req1_ready, req0_done, req1_done}, 32'd0);
    end

    // Single write: req0 addr=2 wdata=3
    adv();
    req0_valid = 1'b1; req0_load = 1'b0; req0_addr = 2'd2; req0_wdata = 2'd3;
    shadow[2] = 2'd3;
    settle();
    check("wr_ready0", 32'(req0_ready), 32'd1);
    check("wr_ready1", 32'(req1_ready), 32'd0);
    push(1'b0, 1'b0, '0);
    adv();
    req0_valid = 1'b0; req0_wdata = 2'd0; req0_addr = 2'd0;
    settle();
    check("wr_access_load", 32'(mem_load), 32'd0);
    check("wr_access_addr", 32'(mem_address), 32'd2);
    check("wr_access_val", 32'(mem_val), 32'd3);
    check("wr_access_done", 32'(req0_done), 32'd0);
    adv(); settle();
    check("wr_done0", 32'(req0_done), 32'd1);
    check("wr_done_load", 32'(mem_load), 32'd1);

    // Read-back: req1 addr=2
    adv();
    req1_valid = 1'b1; req1_load = 1'b1; req1_addr = 2'd2;
    settle();
    check("rb_ready1", 32'(req1_ready), 32'd1);
    check("rb_load_t0", 32'(mem_load), 32'd1);
    push(1'b1, 1'b1, shadow[2]);
    adv();
    req1_valid = 1'b0;
    settle();
    check("rb_load_t1", 32'(mem_load), 32'd1);
    adv(); settle();
    check("rb_done1", 32'(req1_done), 32'd1);
    check("rb_load_t2", 32'(mem_load), 32'd1);

    // Contention: both held valid for four grants
    adv();
    req0_valid = 1'b1; req0_load = 1'b1; req0_addr = 2'd2;
    req1_valid = 1'b1; req1_load = 1'b1; req1_addr = 2'd0;
    for (int g = 0; g < 4; g++) begin
`ifdef MEM_PORT_ARB_FIXED_PRIO_EN
      push(1'b0, 1'b1, shadow[2]);
`else
      push(g[0], 1'b1, g[0] ? shadow[0] : shadow[2]);
`endif
    end
    for (int c = 0; c < 12; c++) begin
      if (c > 0) adv();
      settle();
`ifdef MEM_PORT_ARB_FIXED_PRIO_EN
      check("cont_ready0", 32'(req0_ready), 32'((c % 3) == 0));
      check("cont_ready1", 32'(req1_ready), 32'd0);
`else
      check("cont_ready0", 32'(req0_ready), 32'(c == 0 || c == 6));
      check("cont_ready1", 32'(req1_ready), 32'(c == 3 || c == 9));
`endif
    end
    req0_valid = 1'b0; req1_valid = 1'b0;
    adv(); settle();
    check("cont_after_ready", {30'd0, req0_ready, req1_ready}, 32'd0);

    // Withdrawn request: req1 pulses valid while req0 is in ACCESS
    adv();
    req0_valid = 1'b1; req0_load = 1'b1; req0_addr = 2'd2;
    settle();
    check("wd_ready0_first", 32'(req0_ready), 32'd1);
    push(1'b0, 1'b1, shadow[2]);
    adv();
    req1_valid = 1'b1; req1_load = 1'b1; req1_addr = 2'd0;
    settle();
    check("wd_no_ready1_access", 32'(req1_ready), 32'd0);
    adv();
    req1_valid = 1'b0;
    settle();
    adv(); settle();
    check("wd_ready0_second", 32'(req0_ready), 32'd1);
    check("wd_no_ready1_idle", 32'(req1_ready), 32'd0);
    push(1'b0, 1'b1, shadow[2]);
    adv();
    req0_valid = 1'b0;
    settle();
    adv(); settle();
    for (int c = 0; c < 4; c++) begin
      adv(); settle();
      check("wd_never_ready1", 32'(req1_ready), 32'd0);
    end

    // Reset mid-access: req1 write addr=1 wdata=2
    adv();
    req1_valid = 1'b1; req1_load = 1'b0; req1_addr = 2'd1; req1_wdata = 2'd2;
    settle();
    check("rm_ready1", 32'(req1_ready), 32'd1);
    adv();
    req1_valid = 1'b0;
    settle();
    check("rm_access_load", 32'(mem_load), 32'd0);
    rst = 1'b1;
    adv();
    rst = 1'b0;
    shadow[1] = 2'd2;  // the write in flight lands in Mem at the reset edge
    settle();
    check("rm_load_after", 32'(mem_load), 32'd1);
    check("rm_no_done1", 32'(req1_done), 32'd0);
    adv();
    req1_valid = 1'b1; req1_load = 1'b1; req1_addr = 2'd1;
    settle();
    check("rm_regrant_ready1", 32'(req1_ready), 32'd1);
    push(1'b1, 1'b1, shadow[1]);
    adv();
    req1_valid = 1'b0;
    settle();
    adv(); settle();
    check("rm_regrant_done1", 32'(req1_done), 32'd1);

    adv(); settle();
    check("sb_drained", 32'(sb.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
